// File: rtl/stack_link_ctrl_if.sv
// Operation handshake and data-memory bus that stack_link_ctrl sits between.
// The master side is the controller; the slave side is decode plus memory.
interface stack_link_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [31:0] op_data;
    logic [2:0]  op_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  op_valid, op_code, op_data, op_rd, mem_ack, mem_rdata,
        output op_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output op_valid, op_code, op_data, op_rd, mem_ack, mem_rdata,
        input  op_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/stack_link_ctrl.sv
// Stack and subroutine sequencer: executes PUSH/POP/CALL/RET/SETSP against the
// special register file write ports and a req/ack data memory. All outputs registered.
module stack_link_ctrl #(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
    input  logic                     clk,
    input  logic                     reset,
    stack_link_ctrl_if.master        bus,
    input  logic [31:0]              re_sp,
    input  logic [31:0]              re_lr,
    input  logic [31:0]              re_pc,
    output logic                     wr_sp,
    output logic                     wr_lr,
    output logic                     wr_pc,
    output logic [31:0]              wr_sp_data,
    output logic [31:0]              wr_lr_data,
    output logic [31:0]              wr_pc_data,
    output logic                     wr_usr_enable,
    output logic [2:0]               write_usr_addr,
    output logic [31:0]              usr_data,
    output logic                     done,
    output logic                     fault
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StMem    = 2'd1;
    localparam logic [1:0] StWb     = 2'd2;
    localparam logic [1:0] StSettle = 2'd3;

    localparam logic [2:0] OpPush  = 3'b000;
    localparam logic [2:0] OpPop   = 3'b001;
    localparam logic [2:0] OpCall  = 3'b010;
    localparam logic [2:0] OpRet   = 3'b011;
    localparam logic [2:0] OpSetsp = 3'b100;

    logic [1:0]  state_q, state_d;
    logic        op_ready_q, op_ready_d;
    logic [2:0]  code_q, code_d, rd_q, rd_d;
    logic [31:0] data_q, data_d, sp_q, sp_d, lr_q, lr_d, pc_q, pc_d;
    logic        wr_sp_q, wr_sp_d, wr_lr_q, wr_lr_d, wr_pc_q, wr_pc_d;
    logic [31:0] wr_sp_data_q, wr_sp_data_d, wr_lr_data_q, wr_lr_data_d;
    logic [31:0] wr_pc_data_q, wr_pc_data_d;
    logic        usr_en_q, usr_en_d;
    logic [2:0]  usr_addr_q, usr_addr_d;
    logic [31:0] usr_data_q, usr_data_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d, fault_q, fault_d;

    // In IDLE the op is decided from the live inputs; afterwards from the latched copy.
    logic        in_idle;
    logic [2:0]  cur_code, cur_rd;
    logic [31:0] cur_data, cur_sp, cur_lr, cur_pc, sp_dec, sp_inc;
    logic        is_push, is_pop, is_call, is_ret, stack_err, needs_mem, accept;

    assign in_idle   = (state_q == StIdle);
    assign cur_code  = in_idle ? bus.op_code : code_q;
    assign cur_rd    = in_idle ? bus.op_rd   : rd_q;
    assign cur_data  = in_idle ? bus.op_data : data_q;
    assign cur_sp    = in_idle ? re_sp       : sp_q;
    assign cur_lr    = in_idle ? re_lr       : lr_q;
    assign cur_pc    = in_idle ? re_pc       : pc_q;
    assign sp_dec    = cur_sp - 32'd4;
    assign sp_inc    = cur_sp + 32'd4;
    assign is_push   = (cur_code == OpPush);
    assign is_pop    = (cur_code == OpPop);
    assign is_call   = (cur_code == OpCall);
    assign is_ret    = (cur_code == OpRet);
    assign stack_err = ((is_push || is_call) && (cur_sp < STACK_LIMIT + 32'd4)) ||
                       ((is_pop || is_ret) && (cur_sp >= STACK_BASE));
    assign needs_mem = (is_push || is_pop || is_call || is_ret) && !stack_err;
    assign accept    = in_idle && bus.op_valid && op_ready_q;

    // Write-back pulses for the current op; rdata is only meaningful when leaving MEM.
    logic        wb_sp, wb_lr, wb_pc, wb_usr, wb_fault;
    logic [31:0] wb_sp_data, wb_lr_data, wb_pc_data;

    always_comb begin
        wb_sp      = 1'b0;
        wb_lr      = 1'b0;
        wb_pc      = 1'b0;
        wb_usr     = 1'b0;
        wb_fault   = 1'b0;
        wb_sp_data = '0;
        wb_lr_data = '0;
        wb_pc_data = '0;
        if (stack_err) begin
            wb_fault = 1'b1;
        end else begin
            case (cur_code)
                OpPush: begin
                    wb_sp      = 1'b1;
                    wb_sp_data = sp_dec;
                end
                OpPop: begin
                    wb_usr     = 1'b1;
                    wb_sp      = 1'b1;
                    wb_sp_data = sp_inc;
                end
                OpCall: begin
                    wb_lr      = 1'b1;
                    wb_lr_data = cur_pc + 32'd4;
                    wb_pc      = 1'b1;
                    wb_pc_data = cur_data;
                    wb_sp      = 1'b1;
                    wb_sp_data = sp_dec;
                end
                OpRet: begin
                    wb_pc      = 1'b1;
                    wb_pc_data = cur_lr;
                    wb_lr      = 1'b1;
                    wb_lr_data = bus.mem_rdata;
                    wb_sp      = 1'b1;
                    wb_sp_data = sp_inc;
                end
                OpSetsp: begin
                    if (cur_data >= STACK_LIMIT && cur_data <= STACK_BASE &&
                        cur_data[1:0] == 2'b00) begin
                        wb_sp      = 1'b1;
                        wb_sp_data = cur_data;
                    end else begin
                        wb_fault = 1'b1;
                    end
                end
                default: wb_fault = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        op_ready_d   = 1'b0;
        code_d       = code_q;
        rd_d         = rd_q;
        data_d       = data_q;
        sp_d         = sp_q;
        lr_d         = lr_q;
        pc_d         = pc_q;
        wr_sp_d      = 1'b0;
        wr_lr_d      = 1'b0;
        wr_pc_d      = 1'b0;
        wr_sp_data_d = '0;
        wr_lr_data_d = '0;
        wr_pc_data_d = '0;
        usr_en_d     = 1'b0;
        usr_addr_d   = '0;
        usr_data_d   = '0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        done_d       = 1'b0;
        fault_d      = fault_q;

        case (state_q)
            StIdle: begin
                op_ready_d = 1'b1;
                if (accept) begin
                    op_ready_d = 1'b0;
                    code_d     = bus.op_code;
                    rd_d       = bus.op_rd;
                    data_d     = bus.op_data;
                    sp_d       = re_sp;
                    lr_d       = re_lr;
                    pc_d       = re_pc;
                    if (needs_mem) begin
                        state_d     = StMem;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_push || is_call;
                        mem_addr_d  = (is_push || is_call) ? sp_dec : cur_sp;
                        mem_wdata_d = is_push ? cur_data : (is_call ? cur_lr : 32'd0);
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StMem: begin
                if (bus.mem_ack) begin
                    state_d = StWb;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            StWb:     state_d = StSettle;
            default: begin
                state_d    = StIdle;
                op_ready_d = 1'b1;
            end
        endcase

        if ((accept && !needs_mem) || (state_q == StMem && bus.mem_ack)) begin
            done_d       = 1'b1;
            wr_sp_d      = wb_sp;
            wr_lr_d      = wb_lr;
            wr_pc_d      = wb_pc;
            wr_sp_data_d = wb_sp_data;
            wr_lr_data_d = wb_lr_data;
            wr_pc_data_d = wb_pc_data;
            usr_en_d     = wb_usr;
            usr_addr_d   = wb_usr ? cur_rd : 3'd0;
            usr_data_d   = wb_usr ? bus.mem_rdata : 32'd0;
            fault_d      = fault_q | wb_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            op_ready_q   <= 1'b1;
            code_q       <= '0;
            rd_q         <= '0;
            data_q       <= '0;
            sp_q         <= '0;
            lr_q         <= '0;
            pc_q         <= '0;
            wr_sp_q      <= 1'b0;
            wr_lr_q      <= 1'b0;
            wr_pc_q      <= 1'b0;
            wr_sp_data_q <= '0;
            wr_lr_data_q <= '0;
            wr_pc_data_q <= '0;
            usr_en_q     <= 1'b0;
            usr_addr_q   <= '0;
            usr_data_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_ready_q   <= op_ready_d;
            code_q       <= code_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            sp_q         <= sp_d;
            lr_q         <= lr_d;
            pc_q         <= pc_d;
            wr_sp_q      <= wr_sp_d;
            wr_lr_q      <= wr_lr_d;
            wr_pc_q      <= wr_pc_d;
            wr_sp_data_q <= wr_sp_data_d;
            wr_lr_data_q <= wr_lr_data_d;
            wr_pc_data_q <= wr_pc_data_d;
            usr_en_q     <= usr_en_d;
            usr_addr_q   <= usr_addr_d;
            usr_data_q   <= usr_data_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.op_ready   = op_ready_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign wr_sp          = wr_sp_q;
    assign wr_lr          = wr_lr_q;
    assign wr_pc          = wr_pc_q;
    assign wr_sp_data     = wr_sp_data_q;
    assign wr_lr_data     = wr_lr_data_q;
    assign wr_pc_data     = wr_pc_data_q;
    assign wr_usr_enable  = usr_en_q;
    assign write_usr_addr = usr_addr_q;
    assign usr_data       = usr_data_q;
    assign done           = done_q;
    assign fault          = fault_q;
endmodule

// File: tb/tb_stack_link_ctrl.sv
// Randomised bench for stack_link_ctrl: each op is checked cycle by cycle against
// an abstract stack model (expected memory transfer, write-backs, latency, sticky fault).
module tb_stack_link_ctrl;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] LIMIT = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] re_sp, re_lr, re_pc;
    logic        wr_sp, wr_lr, wr_pc;
    logic [31:0] wr_sp_data, wr_lr_data, wr_pc_data;
    logic        wr_usr_enable;
    logic [2:0]  write_usr_addr;
    logic [31:0] usr_data;
    logic        done, fault;

    stack_link_ctrl_if bus ();

    stack_link_ctrl #(
        .STACK_BASE  (BASE),
        .STACK_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .re_sp          (re_sp),
        .re_lr          (re_lr),
        .re_pc          (re_pc),
        .wr_sp          (wr_sp),
        .wr_lr          (wr_lr),
        .wr_pc          (wr_pc),
        .wr_sp_data     (wr_sp_data),
        .wr_lr_data     (wr_lr_data),
        .wr_pc_data     (wr_pc_data),
        .wr_usr_enable  (wr_usr_enable),
        .write_usr_addr (write_usr_addr),
        .usr_data       (usr_data),
        .done           (done),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit fault_model = 1'b0;

    typedef struct {
        bit          use_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          wsp, wlr, wpc, wusr, err;
        logic [31:0] sp_v, lr_v, pc_v, usr_v;
        logic [2:0]  usr_a;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stack semantics: downward-growing stack, SP points at the last pushed word.
    function automatic exp_t model(input logic [2:0] code, input logic [31:0] data,
                                   input logic [2:0] rd, input logic [31:0] sp,
                                   input logic [31:0] lr, input logic [31:0] pc,
                                   input logic [31:0] rdata);
        exp_t e;
        longint room_below;
        e = '{default: 0};
        room_below = longint'(sp) - 4;
        case (code)
            3'd0, 3'd2: begin
                if (room_below < longint'(LIMIT)) begin
                    e.err = 1;
                end else begin
                    e.use_mem = 1;
                    e.we      = 1;
                    e.addr    = sp - 4;
                    e.wdata   = (code == 3'd0) ? data : lr;
                    e.wsp     = 1;
                    e.sp_v    = sp - 4;
                    if (code == 3'd2) begin
                        e.wlr  = 1;
                        e.lr_v = pc + 4;
                        e.wpc  = 1;
                        e.pc_v = data;
                    end
                end
            end
            3'd1, 3'd3: begin
                if (longint'(sp) >= longint'(BASE)) begin
                    e.err = 1;
                end else begin
                    e.use_mem = 1;
                    e.addr    = sp;
                    e.wsp     = 1;
                    e.sp_v    = sp + 4;
                    if (code == 3'd1) begin
                        e.wusr  = 1;
                        e.usr_a = rd;
                        e.usr_v = rdata;
                    end else begin
                        e.wpc  = 1;
                        e.pc_v = lr;
                        e.wlr  = 1;
                        e.lr_v = rdata;
                    end
                end
            end
            3'd4: begin
                if (data >= LIMIT && data <= BASE && (data % 4) == 0) begin
                    e.wsp  = 1;
                    e.sp_v = data;
                end else begin
                    e.err = 1;
                end
            end
            default: e.err = 1;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [2:0] code, input logic [31:0] data,
                          input logic [2:0] rd, input logic [31:0] sp,
                          input logic [31:0] lr, input logic [31:0] pc,
                          input int delay, input logic [31:0] rdata);
        exp_t e;
        int   reqs;
        int   cyc;
        bit   seen_done;
        e = model(code, data, rd, sp, lr, pc, rdata);
        cyc = 0;
        while (!bus.op_ready && cyc < 10) begin
            tick();
            cyc++;
        end
        check_eq("ready_idle", bus.op_ready, 1);
        re_sp = sp;
        re_lr = lr;
        re_pc = pc;
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_data  = data;
        bus.op_rd    = rd;
        tick();
        bus.op_valid = 1'b0;
        bus.op_data  = $urandom;
        re_sp        = $urandom;
        re_lr        = $urandom;
        re_pc        = $urandom;
        reqs      = 0;
        seen_done = 1'b0;
        for (int c = 1; c <= 20 && !seen_done; c++) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.mem_req) begin
                reqs++;
                check_eq("mem_we", bus.mem_we, e.we);
                check_eq("mem_addr", bus.mem_addr, e.addr);
                if (e.we) check_eq("mem_wdata", bus.mem_wdata, e.wdata);
                if (reqs == delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                fault_model = fault_model | e.err;
                check_eq("done_cycle", c, e.use_mem ? delay + 1 : 1);
                check_eq("req_cycles", reqs, e.use_mem ? delay : 0);
                check_eq("ready_busy", bus.op_ready, 0);
                check_eq("wr_sp", wr_sp, e.wsp);
                check_eq("wr_lr", wr_lr, e.wlr);
                check_eq("wr_pc", wr_pc, e.wpc);
                check_eq("wr_usr", wr_usr_enable, e.wusr);
                if (e.wsp) check_eq("sp_data", wr_sp_data, e.sp_v);
                if (e.wlr) check_eq("lr_data", wr_lr_data, e.lr_v);
                if (e.wpc) check_eq("pc_data", wr_pc_data, e.pc_v);
                if (e.wusr) begin
                    check_eq("usr_addr", write_usr_addr, e.usr_a);
                    check_eq("usr_data", usr_data, e.usr_v);
                end
                check_eq("fault", fault, fault_model);
            end else begin
                tick();
            end
        end
        bus.mem_ack = 1'b0;
        check_eq("done_seen", seen_done, 1);
        tick();
        check_eq("settle_ready", bus.op_ready, 0);
        check_eq("settle_pulses", {done, wr_sp, wr_lr, wr_pc, wr_usr_enable, bus.mem_req}, 0);
        tick();
        check_eq("ready_back", bus.op_ready, 1);
    endtask

    task automatic reset_mid_op();
        run_op(3'd7, 0, 0, BASE, 0, 0, 1, 0);  // make sure fault is set first
        re_sp = BASE;
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd0;
        bus.op_data  = 32'hCAFE_F00D;
        tick();
        bus.op_valid = 1'b0;
        tick();
        check_eq("rst_pre_req", bus.mem_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fault_model = 1'b0;
        check_eq("rst_req", bus.mem_req, 0);
        check_eq("rst_ready", bus.op_ready, 1);
        check_eq("rst_fault", fault, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        tick();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stale_ack", {done, wr_sp, wr_lr, wr_pc, wr_usr_enable, bus.mem_req, fault}, 0);
            check_eq("stale_ready", bus.op_ready, 1);
            tick();
        end
    endtask

    initial begin
        logic [2:0]  code;
        logic [31:0] sp, data, pc;
        reset         = 1'b1;
        bus.op_valid  = 1'b0;
        bus.op_code   = '0;
        bus.op_data   = '0;
        bus.op_rd     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        re_sp = '0;
        re_lr = '0;
        re_pc = '0;
        tick();
        tick();
        check_eq("reset_ready", bus.op_ready, 1);
        check_eq("reset_outs", {done, fault, wr_sp, wr_lr, wr_pc, wr_usr_enable, bus.mem_req}, 0);
        reset = 1'b0;
        tick();

        run_op(3'd0, 32'hDEAD_BEEF, 0, 32'h1000, 0, 0, 3, 0);
        run_op(3'd1, 0, 3'd3, 32'hFFC, 0, 0, 1, 32'h1234_5678);
        run_op(3'd2, 32'h200, 0, 32'h1000, 32'h10, 32'h40, 2, 0);
        run_op(3'd3, 0, 0, 32'hFFC, 32'h44, 32'h200, 1, 32'h10);
        run_op(3'd0, 32'h5, 0, 32'h804, 0, 0, 1, 0);
        run_op(3'd2, 32'h300, 0, 32'h800, 1, 2, 1, 0);
        run_op(3'd1, 0, 1, 32'h1000, 0, 0, 1, 0);
        run_op(3'd0, 32'h77, 0, 32'h1000, 0, 0, 2, 0);
        run_op(3'd4, 32'h802, 0, 32'h900, 0, 0, 1, 0);
        run_op(3'd4, 32'h900, 0, 32'h1000, 0, 0, 1, 0);
        run_op(3'd4, 32'h1000, 0, 32'h900, 0, 0, 1, 0);
        run_op(3'd4, 32'h800, 0, 32'h900, 0, 0, 1, 0);
        run_op(3'd4, 32'h1004, 0, 32'h900, 0, 0, 1, 0);
        run_op(3'd7, 32'h0, 0, 32'h900, 0, 0, 1, 0);
        run_op(3'd2, 32'h80, 0, 32'hF00, 32'h8, 32'hFFFF_FFFC, 1, 0);

        // Randomised traffic, clustered around the stack bounds.
        reset_mid_op();
        for (int n = 0; n < 60; n++) begin
            code = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       sp = LIMIT + 32'(4 * $urandom_range(0, 2));
                1:       sp = BASE - 32'(4 * $urandom_range(0, 2));
                2:       sp = LIMIT + 32'(4 * $urandom_range(0, 512));
                default: sp = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * $urandom_range(0, 2))
                                                          : LIMIT - 32'd4;
            endcase
            if (code == 3'd4 && $urandom_range(0, 1) == 1)
                data = LIMIT - 32'd8 + 32'($urandom_range(0, 32'h810));
            else
                data = $urandom;
            pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
                tick();
                bus.mem_ack = 1'b0;
            end
            run_op(code, data, 3'($urandom_range(0, 7)), sp, $urandom, pc,
                   int'($urandom_range(1, 4)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stack_link_ctrl.md
Name: stack_link_ctrl

Overview:
- Drives the special register file's SP/LR/PC write ports and its user write port to execute stack and subroutine operations: PUSH, POP, CALL, RET, SETSP.
- Reads current SP/LR/PC from the register file's read ports.
- Performs the required data-memory transfers through a req/ack handshake.
- Sits between the decode/control unit (op handshake) and the special register file plus data memory.

Parameters:
- STACK_BASE, 32'h0000_1000, empty-stack SP value (exclusive top; stack grows down).
- STACK_LIMIT, 32'h0000_0800, lowest legal SP value.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  operation request
- op_ready  out  1  block idle, can accept op
- op_code  in  3  000 PUSH, 001 POP, 010 CALL, 011 RET, 100 SETSP, others illegal
- op_data  in  32  PUSH data / CALL target / SETSP value
- op_rd  in  3  POP destination register address
- re_sp, re_lr, re_pc  in  32 each  current SP/LR/PC from register file
- wr_sp, wr_lr, wr_pc  out  1 each  write enables, one-cycle pulses
- wr_sp_data, wr_lr_data, wr_pc_data  out  32 each  write data
- wr_usr_enable  out  1  user-port write enable (POP)
- write_usr_addr  out  3  user-port address
- usr_data  out  32  user-port data
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr, mem_wdata  out  32 each
- mem_ack  in  1  memory completion
- mem_rdata  in  32  read data, valid with mem_ack
- done  out  1  one-cycle completion pulse
- fault  out  1  sticky error flag

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0 except op_ready=1; fault cleared. Reset mid-operation abandons the op, drops mem_req, and performs no register writes. Any later stale mem_ack is ignored.
- FSM states: IDLE, MEM, WB, SETTLE. All outputs are registered.
- IDLE: op_ready=1. On op_valid&op_ready (cycle T), latch op_code, op_data, op_rd, re_sp, re_lr, re_pc.
  - PUSH/CALL: next SP = SP-4. If SP-4 < STACK_LIMIT: overflow, go to WB with no writes and no mem_req.
  - POP/RET: if SP >= STACK_BASE: underflow, same handling.
  - Otherwise go to MEM at T+1.
  - SETSP and illegal opcodes go straight to WB.
- MEM: mem_req=1 from T+1 until mem_ack is sampled high (ack may arrive in the first MEM cycle); address/data/we are stable throughout.
  - PUSH: we=1, addr=SP-4, wdata=op_data.
  - CALL: we=1, addr=SP-4, wdata=LR.
  - POP/RET: we=0, addr=SP. Capture mem_rdata on ack.
  - Next cycle: WB with mem_req=0.
- mem_ack while not in MEM: ignored.
- WB: single cycle; done=1; write pulses as follows.
  - PUSH: wr_sp, SP-4.
  - POP: wr_usr_enable, write_usr_addr=op_rd, usr_data=rdata; wr_sp, SP+4.
  - CALL: wr_lr, PC+4; wr_pc, op_data; wr_sp, SP-4.
  - RET: wr_pc, latched LR; wr_lr, rdata; wr_sp, SP+4.
  - SETSP: if op_data in [STACK_LIMIT, STACK_BASE] and op_data[1:0]==0, wr_sp with op_data; else no write, fault=1.
  - Illegal opcode / overflow / underflow: no writes, fault=1.
- SETTLE: one cycle, op_ready=0, lets the register file capture the WB writes so re_* are current; then IDLE.
- Minimum op latency: accept at T; done at T+1 (no-mem ops) or at T+2+N, where N = cycles from first mem_req to ack; op_ready returns 2 cycles after done... no: op_ready returns in the cycle after SETTLE.
- Arithmetic: 32-bit unsigned, wrap ignored (bounds checks prevent it). PC+4 wraps modulo 2^32.
- fault is sticky until reset and does not block subsequent ops.

Test Plan:
- Reset, SP=0x1000, PUSH 0xDEADBEEF; ack after 3 cycles -> mem write addr 0xFFC data 0xDEADBEEF, held 3 cycles; then wr_sp=1 data 0xFFC with done; op_ready 0 for SETTLE.
- SP=0xFFC, POP op_rd=3, rdata 0x12345678 with ack in first MEM cycle -> read addr 0xFFC; wr_usr_enable, addr 3, data 0x12345678; wr_sp data 0x1000.
- PC=0x40, LR=0x10, SP=0x1000, CALL 0x200 -> mem write 0xFFC/0x10; WB: LR=0x44, PC=0x200, SP=0xFFC. Then RET with rdata 0x10 -> read 0xFFC; PC=0x44, LR=0x10, SP=0x1000.
- SP=0x800, PUSH -> no mem_req, done pulse, fault=1, no wr_*. SP=0x1000, POP -> same. fault stays 1 across a following legal PUSH.
- SETSP 0x802 -> fault, no write; SETSP 0x900 -> wr_sp 0x900; opcode 111 -> fault, done, no writes.
- Reset asserted while in MEM with ack pending; ack arrives after reset -> no register writes, mem_req 0, op_ready 1, fault 0.
